// File: rtl/exu_brupd_q_pkg.sv
// ============================================================================
//  Module   : exu_brupd_q_pkg
//  Purpose  : Shared types for the branch-update queue (predictor training packet).
//  Revision : 1.0
// ============================================================================
`default_nettype none

package exu_brupd_q_pkg;

   typedef struct packed {
      logic [31:1] pc;
      logic [1:0]  hist;
      logic        ataken;
      logic        misp;
      logic        pret;
   } bp_upd_pkt_t;

   function automatic bp_upd_pkt_t pack_upd(input logic [31:1] pc,
                                            input logic [1:0]  hist,
                                            input logic        ataken,
                                            input logic        misp,
                                            input logic        pret);
      bp_upd_pkt_t p;
      p.pc     = pc;
      p.hist   = hist;
      p.ataken = ataken;
      p.misp   = misp;
      p.pret   = pret;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/exu_brupd_q_ptr.sv
// ============================================================================
//  Module   : exu_brupd_q_ptr
//  Purpose  : Wrap-bit queue pointer with increment and (priority) load.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exu_brupd_q_ptr #(
   parameter int unsigned PW = 3
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          i_inc,
   input  logic          i_load,
   input  logic [PW-1:0] i_load_val,
   output logic [PW-1:0] o_ptr,
   output logic [PW-1:0] o_ptr_nxt
);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_nxt;

   always_comb begin
      w_nxt = r_ptr;
      if (i_load)
         w_nxt = i_load_val;
      else if (i_inc)
         w_nxt = r_ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         r_ptr <= '0;
      else
         r_ptr <= w_nxt;
   end

   assign o_ptr     = r_ptr;
   assign o_ptr_nxt = w_nxt;

endmodule

`default_nettype wire

// File: rtl/exu_brupd_q.sv
// ============================================================================
//  Module   : exu_brupd_q
//  Purpose  : Ordered speculative/committed queue of resolved branches feeding
//             predictor training over a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module exu_brupd_q
   import exu_brupd_q_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            enq_valid,
   input  bp_upd_pkt_t     enq_pkt,
   input  logic            commit,
   input  logic            flush_lower,
   output logic            upd_valid,
   input  logic            upd_ready,
   output bp_upd_pkt_t     upd_pkt,
   output logic            full,
   output logic [CNTW-1:0] drop_cnt
);

   localparam int unsigned c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned c_PW = c_IW + 1;

   logic [c_PW-1:0] w_rd, w_cm, w_wr;
   logic [c_PW-1:0] w_rd_nxt, w_cm_nxt, w_wr_nxt;
   logic [c_PW-1:0] w_occ_nxt;
   logic            w_enq, w_drop, w_commit, w_deq;
   logic            r_full;
   logic [CNTW-1:0] r_drop_cnt;
   bp_upd_pkt_t     w_entry [DEPTH];

   // full is the registered view of current occupancy, so a same-cycle
   // dequeue never makes room for a same-cycle enqueue.
   assign w_enq    = enq_valid & ~r_full & ~flush_lower;
   assign w_drop   = enq_valid &  r_full & ~flush_lower;
   assign w_commit = commit & (w_cm != w_wr);
   assign w_deq    = upd_valid & upd_ready;

   exu_brupd_q_ptr #(.PW(c_PW)) u_rd_ptr (
      .clk        (clk),
      .rst_l      (rst_l),
      .i_inc      (w_deq),
      .i_load     (1'b0),
      .i_load_val ({c_PW{1'b0}}),
      .o_ptr      (w_rd),
      .o_ptr_nxt  (w_rd_nxt)
   );

   exu_brupd_q_ptr #(.PW(c_PW)) u_cm_ptr (
      .clk        (clk),
      .rst_l      (rst_l),
      .i_inc      (w_commit),
      .i_load     (1'b0),
      .i_load_val ({c_PW{1'b0}}),
      .o_ptr      (w_cm),
      .o_ptr_nxt  (w_cm_nxt)
   );

   // A flush rewinds the write pointer to the post-commit boundary.
   exu_brupd_q_ptr #(.PW(c_PW)) u_wr_ptr (
      .clk        (clk),
      .rst_l      (rst_l),
      .i_inc      (w_enq),
      .i_load     (flush_lower),
      .i_load_val (w_cm_nxt),
      .o_ptr      (w_wr),
      .o_ptr_nxt  (w_wr_nxt)
   );

   assign w_occ_nxt = w_wr_nxt - w_rd_nxt;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_full     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_full <= (w_occ_nxt == c_PW'(DEPTH));
         if (w_drop && (r_drop_cnt != {CNTW{1'b1}}))
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      bp_upd_pkt_t r_pkt;
      logic        w_we;

      assign w_we = w_enq & (w_wr[c_IW-1:0] == c_IW'(i));

      always_ff @(posedge clk) begin
         if (w_we)
            r_pkt <= enq_pkt;
      end

      assign w_entry[i] = r_pkt;
   end

   assign upd_valid = (w_rd != w_cm);
   assign upd_pkt   = w_entry[w_rd[c_IW-1:0]];
   assign full      = r_full;
   assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exu_brupd_q.sv
// ============================================================================
//  Module   : tb_exu_brupd_q
//  Purpose  : Directed self-checking bench for exu_brupd_q (DEPTH=4, CNTW=8).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exu_brupd_q;
   import exu_brupd_q_pkg::*;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        enq_valid;
   bp_upd_pkt_t enq_pkt;
   logic        commit;
   logic        flush_lower;
   logic        upd_valid;
   logic        upd_ready;
   bp_upd_pkt_t upd_pkt;
   logic        full;
   logic [7:0]  drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   exu_brupd_q #(.DEPTH(4), .CNTW(8)) dut (
      .clk         (clk),
      .rst_l       (rst_l),
      .enq_valid   (enq_valid),
      .enq_pkt     (enq_pkt),
      .commit      (commit),
      .flush_lower (flush_lower),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_pkt     (upd_pkt),
      .full        (full),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bp_upd_pkt_t mk(input logic [31:0] pc, input logic misp);
      return pack_upd(pc[31:1], pc[3:2], pc[4], misp, pc[5]);
   endfunction

   task automatic cyc(input logic ev, input bp_upd_pkt_t p, input logic cm,
                      input logic fl, input logic rdy);
      enq_valid   = ev;
      enq_pkt     = p;
      commit      = cm;
      flush_lower = fl;
      upd_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   // Pointer ordering and stall stability, sampled mid-cycle
   logic        stalled = 1'b0;
   bp_upd_pkt_t held;
   always @(negedge clk) begin
      if (!rst_l) begin
         stalled = 1'b0;
      end else begin
         chk("cm_not_past_wr", 64'(3'(dut.w_wr - dut.w_cm) <= 3'd4), 64'd1);
         chk("rd_not_past_cm", 64'(3'(dut.w_cm - dut.w_rd) <= 3'd4), 64'd1);
         if (stalled) begin
            chk("stall_valid", 64'(upd_valid), 64'd1);
            chk("stall_pkt", 64'(upd_pkt), 64'(held));
         end
         stalled = upd_valid & ~upd_ready;
         held    = upd_pkt;
      end
   end

   bp_upd_pkt_t nil;
   bp_upd_pkt_t p4 [4];
   bp_upd_pkt_t sbq [$];

   initial begin
      nil = '0;
      rst_l = 1'b0;
      enq_valid = 1'b0; enq_pkt = '0; commit = 1'b0; flush_lower = 1'b0; upd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(upd_valid), 64'd0);
      chk("rst_full",  64'(full), 64'd0);
      chk("rst_drop",  64'(drop_cnt), 64'd0);
      rst_l = 1'b1;

      // single entry: enqueue, commit, drain
      cyc(1, mk(32'h100, 1'b1), 0, 0, 1);
      chk("t1_spec_invisible", 64'(upd_valid), 64'd0);
      cyc(0, nil, 1, 0, 1);
      chk("t1_valid", 64'(upd_valid), 64'd1);
      chk("t1_pkt", 64'(upd_pkt), 64'(mk(32'h100, 1'b1)));
      chk("t1_pc", 64'(upd_pkt.pc), 64'h80);
      chk("t1_misp", 64'(upd_pkt.misp), 64'd1);
      cyc(0, nil, 0, 0, 1);
      chk("t1_drop_valid", 64'(upd_valid), 64'd0);

      // 3 enqueued, 1 committed, then flush
      cyc(1, mk(32'h200, 0), 0, 0, 0);
      cyc(1, mk(32'h204, 0), 0, 0, 0);
      cyc(1, mk(32'h208, 1), 0, 0, 0);
      cyc(0, nil, 1, 0, 0);
      cyc(0, nil, 0, 1, 0);
      chk("t2_valid", 64'(upd_valid), 64'd1);
      chk("t2_pkt", 64'(upd_pkt), 64'(mk(32'h200, 0)));
      chk("t2_full", 64'(full), 64'd0);
      cyc(0, nil, 0, 0, 1);
      chk("t2_empty", 64'(upd_valid), 64'd0);
      cyc(0, nil, 1, 0, 1);
      chk("t2_no_ghost", 64'(upd_valid), 64'd0);

      // fill, overflow with drops, drain in order across the wrap
      for (int i = 0; i < 4; i++) p4[i] = mk(32'h300 + 32'(i) * 32'h10, i[0]);
      cyc(1, p4[0], 0, 0, 0);
      cyc(1, p4[1], 1, 0, 0);
      cyc(1, p4[2], 1, 0, 0);
      cyc(1, p4[3], 1, 0, 0);
      chk("t3_full", 64'(full), 64'd1);
      cyc(1, mk(32'h3f0, 1), 1, 0, 0);
      cyc(1, mk(32'h3f4, 1), 0, 0, 0);
      chk("t3_full2", 64'(full), 64'd1);
      chk("t3_drop", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 4; i++) begin
         chk("t3_drain_valid", 64'(upd_valid), 64'd1);
         chk("t3_drain_pkt", 64'(upd_pkt), 64'(p4[i]));
         cyc(0, nil, 0, 0, 1);
      end
      chk("t3_empty", 64'(upd_valid), 64'd0);
      chk("t3_not_full", 64'(full), 64'd0);

      // commit + enqueue + flush together with one speculative entry
      cyc(1, mk(32'h400, 1), 0, 0, 0);
      cyc(1, mk(32'h404, 0), 1, 1, 0);
      chk("t4_valid", 64'(upd_valid), 64'd1);
      chk("t4_pkt", 64'(upd_pkt), 64'(mk(32'h400, 1)));
      chk("t4_drop", 64'(drop_cnt), 64'd2);
      cyc(0, nil, 0, 0, 1);
      chk("t4_empty", 64'(upd_valid), 64'd0);
      cyc(0, nil, 1, 0, 1);
      chk("t4_discarded", 64'(upd_valid), 64'd0);

      // streaming with ready toggling every 3 cycles
      begin
         int com, spec, kn;
         logic rdy, en, deq, cok;
         com = 0; spec = 0; kn = 0;
         for (int k = 0; k < 40; k++) begin
            if (k >= 20 && com + spec == 0) break;
            rdy = (k >= 20) ? 1'b1 : (((k / 3) % 2) == 0);
            chk("t5_full", 64'(full), 64'(com + spec == 4));
            chk("t5_valid", 64'(upd_valid), 64'(com > 0));
            if (com > 0) chk("t5_pkt", 64'(upd_pkt), 64'(sbq[0]));
            en  = (k < 20) && (com + spec < 4);
            deq = (com > 0) && rdy;
            cok = (spec > 0);
            cyc(en, mk(32'h1000 + 32'(kn) * 4, kn[0]), 1, 0, rdy);
            if (deq) void'(sbq.pop_front());
            if (en) begin
               sbq.push_back(mk(32'h1000 + 32'(kn) * 4, kn[0]));
               kn++;
            end
            com  = com - int'(deq) + int'(cok);
            spec = spec - int'(cok) + int'(en);
         end
         chk("t5_drained", 64'(upd_valid), 64'd0);
         chk("t5_no_drop", 64'(drop_cnt), 64'd2);
      end

      // drop counter saturation
      for (int i = 0; i < 4; i++) cyc(1, mk(32'h500 + 32'(i) * 4, 0), 0, 0, 0);
      for (int i = 0; i < 253; i++) cyc(1, mk(32'h5f0, 0), 0, 0, 0);
      chk("t6_drop_max", 64'(drop_cnt), 64'hff);
      cyc(1, mk(32'h5f0, 0), 0, 0, 0);
      chk("t6_drop_sat", 64'(drop_cnt), 64'hff);
      cyc(0, nil, 0, 1, 0);
      chk("t6_flush_full", 64'(full), 64'd0);
      chk("t6_flush_valid", 64'(upd_valid), 64'd0);

      // asynchronous reset mid-drain
      cyc(1, mk(32'h600, 1), 0, 0, 0);
      cyc(1, mk(32'h604, 0), 1, 0, 0);
      cyc(0, nil, 1, 0, 0);
      chk("t7_valid", 64'(upd_valid), 64'd1);
      chk("t7_pkt", 64'(upd_pkt), 64'(mk(32'h600, 1)));
      #2;
      rst_l = 1'b0;
      #1;
      chk("t7_async_valid", 64'(upd_valid), 64'd0);
      chk("t7_async_drop", 64'(drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      cyc(0, nil, 1, 0, 1);
      cyc(0, nil, 1, 0, 1);
      chk("t7_post_valid", 64'(upd_valid), 64'd0);
      chk("t7_post_full", 64'(full), 64'd0);
      chk("t7_post_drop", 64'(drop_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
